cpu_step_ctrl: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 13 +
 rtl/btn_debounce.sv | 40 ++++
 rtl/cpu_step_ctrl.sv | 120 ++++++++++++
 tb/tb_cpu_step_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and state encoding for the CPU execution sequencer.
package cpu_ctrl_pkg;

    localparam int CPU_PC_W = 32;

    // Encodings are exported to the LCD mux; 2'b11 is reserved and never used.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } ctrl_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// single-cycle pulse on the rising edge of the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic [1:0] sync;
    logic [7:0] cnt;
    logic       level;
    logic       level_q;

    // Level is high once the synced input has been high for DEBOUNCE_CYCLES samples.
    assign level = (cnt == 8'(DEBOUNCE_CYCLES));
    assign pulse = level & ~level_q;

    // Synchronize the raw button; only sync[1] is used downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[0], btn};
    end

    // Count consecutive high samples; hold at the threshold so a long press never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           cnt <= '0;
        else if (!sync[1]) cnt <= '0;
        else if (!level)   cnt <= cnt + 8'd1;
    end

    // Delayed level for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) level_q <= 1'b0;
        else     level_q <= level;
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Execution sequencer: turns the step button and run switch into a one-cycle
// CPU clock-enable, with paced free-run and a PC breakpoint halt.
module cpu_step_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int RUN_DIV         = 8,
    parameter int CNT_W           = 16
) (
    input  logic                CCLK,
    input  logic                reset,
    input  logic                step_btn,
    input  logic                run_sw,
    input  logic                bp_en,
    input  logic [CPU_PC_W-1:0] bp_addr,
    input  logic [CPU_PC_W-1:0] pc,
    output logic                cpu_en,
    output logic                halted,
    output logic [1:0]          state,
    output logic [CNT_W-1:0]    step_cnt
);

    localparam logic [15:0] PACE_RELOAD = 16'(RUN_DIV - 1);

    logic        step_req;
    logic [1:0]  run_sync;
    logic        run_s;
    ctrl_state_t state_q, state_d;
    logic [15:0] pace_q, pace_d;
    logic        skip_q, skip_d;
    logic        en_d;
    logic        bp_hit;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk   (CCLK),
        .rst   (reset),
        .btn   (step_btn),
        .pulse (step_req)
    );

    assign run_s  = run_sync[1];
    assign bp_hit = bp_en && (pc == bp_addr) && !skip_q;
    assign state  = state_q;
    assign halted = (state_q == HALT);

    // Run switch synchronizer.
    always_ff @(posedge CCLK or posedge reset) begin
        if (reset) run_sync <= '0;
        else       run_sync <= {run_sync[0], run_sw};
    end

    // State, pacing, breakpoint-skip and registered enable.
    always_ff @(posedge CCLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pace_q  <= '0;
            skip_q  <= 1'b0;
            cpu_en  <= 1'b0;
        end else begin
            state_q <= state_d;
            pace_q  <= pace_d;
            skip_q  <= skip_d;
            cpu_en  <= en_d;
        end
    end

    // Next-state logic; any issued pulse consumes the breakpoint skip.
    always_comb begin
        state_d = state_q;
        pace_d  = pace_q;
        skip_d  = skip_q;
        en_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (step_req) begin
                    en_d   = 1'b1;
                    skip_d = 1'b0;
                end
                if (run_s) begin
                    state_d = RUN;
                    pace_d  = PACE_RELOAD;
                end
            end
            RUN: begin
                if (pace_q == 16'd0) begin
                    pace_d = PACE_RELOAD;
                    if (bp_hit) begin
                        state_d = HALT;
                    end else begin
                        en_d   = 1'b1;
                        skip_d = 1'b0;
                    end
                end else begin
                    pace_d = pace_q - 16'd1;
                end
                // Leaving run takes priority over a breakpoint halt.
                if (!run_s) state_d = IDLE;
            end
            HALT: begin
                if (step_req) begin
                    en_d    = 1'b1;
                    skip_d  = 1'b1;
                    pace_d  = PACE_RELOAD;
                    state_d = run_s ? RUN : IDLE;
                end else if (!run_s) begin
                    state_d = IDLE;
                    skip_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating count of issued enables.
    always_ff @(posedge CCLK or posedge reset) begin
        if (reset)                        step_cnt <= '0;
        else if (cpu_en && !(&step_cnt))  step_cnt <= step_cnt + 1'b1;
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl: directed scenarios plus randomized
// presses and run windows, checked against timing rules computed in the bench.
module tb_cpu_step_ctrl;

    localparam int D   = 3;
    localparam int DIV = 8;

    logic        CCLK = 1'b0;
    logic        reset = 1'b1;
    logic        step_btn = 1'b0;
    logic        run_sw = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'h0;
    logic [31:0] pc;

    logic        cpu_en, halted;
    logic [1:0]  state;
    logic [15:0] step_cnt;
    logic        cpu_en_s, halted_s;
    logic [1:0]  state_s;
    logic [3:0]  step_cnt_s;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc = 0;
    int n_pulse = 0;
    int last_pulse = 0;
    int exp_cnt = 0;
    int c0, c1, k, p, n0, len, gap;

    cpu_step_ctrl #(.DEBOUNCE_CYCLES(D), .RUN_DIV(DIV), .CNT_W(16)) dut (
        .CCLK(CCLK), .reset(reset), .step_btn(step_btn), .run_sw(run_sw),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .cpu_en(cpu_en), .halted(halted), .state(state), .step_cnt(step_cnt)
    );

    cpu_step_ctrl #(.DEBOUNCE_CYCLES(D), .RUN_DIV(DIV), .CNT_W(4)) dut_sat (
        .CCLK(CCLK), .reset(reset), .step_btn(step_btn), .run_sw(run_sw),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .cpu_en(cpu_en_s), .halted(halted_s), .state(state_s), .step_cnt(step_cnt_s)
    );

    always #5 CCLK = ~CCLK;

    // Edge counter: after edge n, cyc == n.
    always @(posedge CCLK) cyc <= cyc + 1;

    // CPU stand-in: commits one instruction (pc += 4) per enable.
    always @(posedge CCLK or posedge reset) begin
        if (reset)       pc <= 32'h0;
        else if (cpu_en) pc <= pc + 32'd4;
    end

    // Record every enable pulse and the edge that raised it.
    always @(negedge CCLK) begin
        if (cpu_en) begin
            n_pulse    = n_pulse + 1;
            last_pulse = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CCLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tot++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Pulses of a run window: first at k+2+DIV, then every DIV, last possible at c1+3.
    function automatic int run_pulses(input int first, input int stop);
        int n = 0;
        for (int t = first; t <= stop; t += DIV) n++;
        return n;
    endfunction

    initial begin
        // Reset state
        tick(3);
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_halted", halted, 0);
        chk("rst_state", state, 0);
        chk("rst_cnt", step_cnt, 0);
        reset = 1'b0;
        tick(2);

        // Single step: 5-cycle press, one pulse at k+2+D
        c0 = cyc; k = c0 + 1; n0 = n_pulse;
        step_btn = 1'b1; tick(5); step_btn = 1'b0; tick(8);
        exp_cnt++;
        chk("step_pulses", n_pulse - n0, 1);
        chk("step_latency", last_pulse, k + 2 + D);
        chk("step_cnt1", step_cnt, exp_cnt);
        chk("step_state", state, 0);

        // Held button: one pulse only
        n0 = n_pulse;
        step_btn = 1'b1; tick(50); step_btn = 1'b0; tick(6);
        exp_cnt++;
        chk("held_pulses", n_pulse - n0, 1);

        // Short glitch: no pulse
        n0 = n_pulse;
        step_btn = 1'b1; tick(2); step_btn = 1'b0; tick(8);
        chk("glitch_pulses", n_pulse - n0, 0);
        chk("glitch_cnt", step_cnt, exp_cnt);

        // Random press lengths: a press issues iff it lasts at least D samples
        for (int i = 0; i < 8; i++) begin
            len = int'($urandom_range(1, 6));
            gap = int'($urandom_range(5, 8));
            c0 = cyc; k = c0 + 1; n0 = n_pulse;
            step_btn = 1'b1; tick(len); step_btn = 1'b0; tick(gap);
            if (len >= D) begin
                exp_cnt++;
                chk("rnd_latency", last_pulse, k + 2 + D);
            end
            chk("rnd_pulses", n_pulse - n0, (len >= D) ? 1 : 0);
            chk("rnd_cnt", step_cnt, exp_cnt);
        end

        // Free run: one directed 84-cycle window, then random windows
        for (int w = 0; w < 3; w++) begin
            len = (w == 0) ? 84 : int'($urandom_range(20, 70));
            c0 = cyc; k = c0 + 1; n0 = n_pulse;
            run_sw = 1'b1; tick(len);
            c1 = cyc; run_sw = 1'b0; tick(8);
            chk("run_pulses", n_pulse - n0, run_pulses(k + 2 + DIV, c1 + 3));
            if (w == 0) chk("run_last", last_pulse, k + 2 + DIV * 10);
            exp_cnt += run_pulses(k + 2 + DIV, c1 + 3);
            n0 = n_pulse; tick(20);
            chk("run_stopped", n_pulse - n0, 0);
            chk("run_state", state, 0);
            chk("run_cnt", step_cnt, exp_cnt);
            chk("run_pc", pc, 4 * exp_cnt);
        end

        // Breakpoint from reset: pc walks 0,4,...,0x34 -> halt after 13 issues
        reset = 1'b1; tick(1); reset = 1'b0; exp_cnt = 0;
        bp_en = 1'b1; bp_addr = 32'h34;
        c0 = cyc; k = c0 + 1;
        run_sw = 1'b1;
        for (int i = 0; i < 400 && !halted; i++) tick(1);
        chk("bp_halted", halted, 1);
        chk("bp_halt_edge", cyc, k + 2 + DIV * 14);
        chk("bp_pc", pc, 32'h34);
        chk("bp_cnt", step_cnt, 13);
        chk("bp_state", state, 2'b10);
        tick(10);
        chk("bp_stays", halted, 1);
        chk("bp_no_en", cpu_en, 0);
        exp_cnt = 13;

        // Release with a step while run_sw=1: one pulse, then paced run resumes
        c0 = cyc; k = c0 + 1; p = k + 2 + D; n0 = n_pulse;
        step_btn = 1'b1;
        for (int i = 0; i < 20 && n_pulse == n0; i++) tick(1);
        chk("rel_edge", last_pulse, p);
        tick(1);
        chk("rel_pc", pc, 32'h38);
        chk("rel_state", state, 2'b01);
        step_btn = 1'b0;
        tick(40);
        c1 = cyc; run_sw = 1'b0; tick(8);
        exp_cnt += run_pulses(p, c1 + 3);
        chk("rel_cnt", step_cnt, exp_cnt);
        chk("rel_pc_run", pc, 4 * exp_cnt);
        chk("rel_halted", halted, 0);

        // Switch off in HALT, then on again: the breakpoint instruction passes
        reset = 1'b1; tick(1); reset = 1'b0; exp_cnt = 13;
        run_sw = 1'b1;
        for (int i = 0; i < 400 && !halted; i++) tick(1);
        chk("skip_halted", halted, 1);
        run_sw = 1'b0; tick(6);
        chk("skip_idle", state, 0);
        chk("skip_unhalted", halted, 0);
        c0 = cyc; k = c0 + 1;
        run_sw = 1'b1; tick(40);
        c1 = cyc; run_sw = 1'b0; tick(8);
        exp_cnt += run_pulses(k + 2 + DIV, c1 + 3);
        chk("skip_pc", pc, 4 * exp_cnt);
        chk("skip_cnt", step_cnt, exp_cnt);

        // Asynchronous reset right after an enable edge
        bp_en = 1'b0;
        run_sw = 1'b1;
        for (int i = 0; i < 40 && !cpu_en; i++) tick(1);
        chk("ar_seen_en", cpu_en, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_cpu_en", cpu_en, 0);
        chk("ar_cnt", step_cnt, 0);
        chk("ar_state", state, 0);
        chk("ar_sat_cnt", step_cnt_s, 0);
        run_sw = 1'b0; tick(2); reset = 1'b0; exp_cnt = 0; tick(2);

        // Long run: 16-bit count tracks, 4-bit count saturates at 15
        c0 = cyc; k = c0 + 1;
        run_sw = 1'b1; tick(200);
        c1 = cyc; run_sw = 1'b0; tick(8);
        exp_cnt = run_pulses(k + 2 + DIV, c1 + 3);
        chk("sat_cnt16", step_cnt, exp_cnt);
        chk("sat_cnt4", step_cnt_s, (exp_cnt > 15) ? 15 : exp_cnt);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

endmodule
